// File: rtl/pipeline_ctrl.sv
// Purpose : hazard sequencer for the 5-stage F/D/E/M/W pipe: stage-register stall/flush
//           enables, E-stage operand forwarding selects, data-memory wait FSM with sticky
//           timeout error, and a saturating stall-cycle counter.
// Latency : stall/flush/forward outputs are combinational from current state and inputs;
//           FSM state, MemErr and StallCount update on the rising clock edge.
// Backpressure: a not-ready memory access in M freezes F..M and bubbles W until ready;
//           after MAX_WAIT further not-ready cycles the pipe freezes in ERR until reset.
//
// Ports:
//   clk, reset                synchronous active-high reset
//   Rs1D, Rs2D                source registers of the instruction in D
//   Rs1E, Rs2E                source registers of the instruction in E
//   RdE, RdM, RdW             destination registers in E/M/W
//   ResultSrcE0               instruction in E is a load
//   RegWriteM, RegWriteW      instruction in M/W writes its rd
//   PCSrcE                    taken branch/jump resolved in E
//   MemReqM, MemReadyM        data memory request in M / completion this cycle
//   StallF/D/E/M              hold PC, F/D, D/E, E/M registers
//   FlushD/E/W                clear F/D, D/E, M/W registers
//   ForwardAE, ForwardBE      00 regfile, 01 W result, 10 M ALU result
//   MemErr                    sticky memory-timeout error
//   StallCount                saturating count of stalled cycles
module pipeline_ctrl #(
  parameter int MAX_WAIT = 15,
  parameter int WAIT_W   = 4,
  parameter int CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [4:0]       Rs1D,
  input  logic [4:0]       Rs2D,
  input  logic [4:0]       Rs1E,
  input  logic [4:0]       Rs2E,
  input  logic [4:0]       RdE,
  input  logic [4:0]       RdM,
  input  logic [4:0]       RdW,
  input  logic             ResultSrcE0,
  input  logic             RegWriteM,
  input  logic             RegWriteW,
  input  logic             PCSrcE,
  input  logic             MemReqM,
  input  logic             MemReadyM,
  output logic             StallF,
  output logic             StallD,
  output logic             StallE,
  output logic             StallM,
  output logic             FlushD,
  output logic             FlushE,
  output logic             FlushW,
  output logic [1:0]       ForwardAE,
  output logic [1:0]       ForwardBE,
  output logic             MemErr,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    MWAIT = 2'd1,
    ERR   = 2'd2
  } state_t;

  localparam logic [WAIT_W-1:0] MAX_WAIT_C = WAIT_W'(MAX_WAIT);
  localparam logic [1:0] FWD_RF = 2'b00;
  localparam logic [1:0] FWD_W  = 2'b01;
  localparam logic [1:0] FWD_M  = 2'b10;

  state_t            state;
  logic [WAIT_W-1:0] wait_cnt;
  logic              mem_stall;
  logic              lw_stall;

  // Memory stall: a fresh not-ready request in RUN stalls immediately (no
  // cycle lost entering MWAIT); in MWAIT the stall drops in the same cycle
  // ready arrives; ERR freezes the pipe until reset.
  always_comb begin
    mem_stall = 1'b0;
    case (state)
      RUN:     mem_stall = MemReqM & ~MemReadyM;
      MWAIT:   mem_stall = ~MemReadyM;
      ERR:     mem_stall = 1'b1;
      default: mem_stall = 1'b0;
    endcase
  end

  // Load-use: a load in E whose rd feeds the instruction in D. x0 never hazards.
  always_comb begin
    lw_stall = ResultSrcE0 & (RdE != 5'd0) & ((RdE == Rs1D) | (RdE == Rs2D));
  end

  // Forwarding select for one E operand; the younger M result beats W.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs);
    logic [1:0] sel;
    sel = FWD_RF;
    if (RegWriteM && (RdM != 5'd0) && (RdM == rs))
      sel = FWD_M;
    else if (RegWriteW && (RdW != 5'd0) && (RdW == rs))
      sel = FWD_W;
    return sel;
  endfunction

  always_comb begin
    StallF    = 1'b0;
    StallD    = 1'b0;
    StallE    = 1'b0;
    StallM    = 1'b0;
    FlushD    = 1'b0;
    FlushE    = 1'b0;
    FlushW    = 1'b0;
    ForwardAE = fwd_sel(Rs1E);
    ForwardBE = fwd_sel(Rs2E);

    if (reset) begin
      // Keep every stage register clearing while reset is held.
      FlushD    = 1'b1;
      FlushE    = 1'b1;
      FlushW    = 1'b1;
      ForwardAE = FWD_RF;
      ForwardBE = FWD_RF;
    end else if (mem_stall) begin
      // Freeze F..M and bubble W. Branch flushes are deferred: E is held, so
      // PCSrcE is presented again in the cycle the stall releases.
      StallF = 1'b1;
      StallD = 1'b1;
      StallE = 1'b1;
      StallM = 1'b1;
      FlushW = 1'b1;
    end else if (lw_stall) begin
      // Hold F/D, inject a bubble into E; a taken branch still kills D.
      StallF = 1'b1;
      StallD = 1'b1;
      FlushE = 1'b1;
      FlushD = PCSrcE;
    end else begin
      FlushD = PCSrcE;
      FlushE = PCSrcE;
    end
  end

  // Memory wait FSM. wait_cnt counts not-ready cycles since the request,
  // including the RUN cycle that raised it, so ERR follows MAX_WAIT+1 stalls.
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= RUN;
      wait_cnt <= '0;
      MemErr   <= 1'b0;
    end else begin
      case (state)
        RUN: begin
          if (MemReqM && !MemReadyM) begin
            state    <= MWAIT;
            wait_cnt <= WAIT_W'(1);
          end
        end
        MWAIT: begin
          if (MemReadyM) begin
            state    <= RUN;
            wait_cnt <= '0;
          end else if (wait_cnt == MAX_WAIT_C) begin
            state  <= ERR;
            MemErr <= 1'b1;
          end else begin
            wait_cnt <= wait_cnt + WAIT_W'(1);
          end
        end
        ERR: begin
          MemErr <= 1'b1;
        end
        default: begin
          state    <= RUN;
          wait_cnt <= '0;
        end
      endcase
    end
  end

  // Stall-cycle counter: sticks at all-ones rather than wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      StallCount <= '0;
    end else if ((mem_stall || lw_stall) && !(&StallCount)) begin
      StallCount <= StallCount + CNT_W'(1);
    end
  end

endmodule
